// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD operand packer and its pair FIFO.
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef struct packed {
        logic [GCD_WIDTH-1:0] a;
        logic [GCD_WIDTH-1:0] b;
    } gcd_pair_t;

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } gcd_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/gcd_pair_fifo.sv
// Generic registered FIFO; pointers carry one extra wrap bit to tell full from empty.
module gcd_pair_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] wr_data,
    input  logic          pop,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; the empty mask below keeps stale entries off rd_data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/gcd_operand_packer.sv
// Pairs consecutive operands into {first, second} words for the GCD engine.
// Define GCD_ZERO_FILTER_EN to drop pairs containing a zero operand and expose drop_cnt.
module gcd_operand_packer
    import gcd_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] out_data,
    input  logic               out_ready
`ifdef GCD_ZERO_FILTER_EN
    ,
    output logic [7:0]         drop_cnt
`endif
);

    gcd_state_t       state;
    logic [WIDTH-1:0] hold;
    logic             fifo_full;
    logic             fifo_empty;
    logic             zero_pair;
    logic             in_xfer;
    logic             pair_done;
    logic             push;

`ifdef GCD_ZERO_FILTER_EN
    assign zero_pair = (hold == '0) || (in_data == '0);
`else
    assign zero_pair = 1'b0;
`endif

    // A zero pair is never stored, so it may complete even when the FIFO is full.
    assign in_ready  = (state == WAIT_A) || !fifo_full || zero_pair;
    assign in_xfer   = in_valid && in_ready;
    assign pair_done = in_xfer && (state == WAIT_B) && !flush;
    assign push      = pair_done && !zero_pair;
    assign out_valid = !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_A;
            hold  <= '0;
        end else if (flush) begin
            state <= WAIT_A;
            hold  <= '0;
        end else if (in_xfer) begin
            case (state)
                WAIT_A: begin
                    hold  <= in_data;
                    state <= WAIT_B;
                end
                default: state <= WAIT_A;
            endcase
        end
    end

`ifdef GCD_ZERO_FILTER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (pair_done && zero_pair) begin
            drop_cnt <= sat_inc8(drop_cnt);
        end
    end
`endif

    gcd_pair_fifo #(
        .DEPTH (DEPTH),
        .DW    (2 * WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .wr_data ({hold, in_data}),
        .pop     (out_ready),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_gcd_operand_packer.sv
// Directed bench for gcd_operand_packer with a queue scoreboard of expected pairs.
module tb_gcd_operand_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
`ifdef GCD_ZERO_FILTER_EN
    logic [7:0]  drop_cnt;
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    bit          have_a = 1'b0;
    logic [15:0] a_val = '0;
    int          exp_drops = 0;
    bit          acc;

    always #5 clk = ~clk;

    gcd_operand_packer dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef GCD_ZERO_FILTER_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference pairing: accepted operands pair up in order, zero pairs dropped when filtering.
    task automatic model(input logic [15:0] d);
        if (!have_a) begin
            a_val  = d;
            have_a = 1'b1;
        end else begin
            have_a = 1'b0;
            if (FILTER && (a_val == 16'h0 || d == 16'h0)) begin
                if (exp_drops < 255) exp_drops++;
            end else begin
                exp_q.push_back({a_val, d});
            end
        end
    endtask

    // One clock: sample at negedge, score any output transfer, then step past the rising edge.
    task automatic tick();
        logic [31:0] exp;
        @(negedge clk);
        acc = in_valid && in_ready && !flush && !rst;
        if (!flush && !rst) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {31'd0, out_valid}, 32'd0);
            end else if (out_valid && out_ready) begin
                exp = exp_q.pop_front();
                check("pair_out", out_data, exp);
            end
        end
        if (acc) model(in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        in_valid = 1'b1;
        in_data  = v;
        acc      = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) tick();
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
`ifdef GCD_ZERO_FILTER_EN
        check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
`endif

        // Basic pairing with one-cycle latency
        out_ready = 1'b1;
        send(16'h0030);
        send(16'h0020);
        check("basic_valid", {31'd0, out_valid}, 32'd1);
        check("basic_data", out_data, 32'h0030_0020);
        drain();

        // Backpressure: two pairs queued, fifth operand waits in WAIT_B
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(16'(i));
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_head", out_data, 32'h0001_0002);
        in_valid = 1'b1;
        in_data  = 16'd6;
        tick();
        check("bp_hold_data", out_data, 32'h0001_0002);
        check("bp_still_blocked", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        send(16'd6);
        drain();

        // Simultaneous push and pop with one pair queued
        out_ready = 1'b0;
        send(16'd7);
        send(16'd8);
        send(16'd9);
        out_ready = 1'b1;
        send(16'd10);
        check("pp_valid", {31'd0, out_valid}, 32'd1);
        check("pp_next", out_data, 32'h0009_000A);
        drain();

        // Flush discards the held operand
        send(16'h0007);
        flush = 1'b1;
        tick();
        flush  = 1'b0;
        have_a = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        send(16'h0009);
        send(16'h0003);
        check("flush_pair", out_data, 32'h0009_0003);
        drain();

        // Flush beats queued output and a concurrent input
        out_ready = 1'b0;
        send(16'h0001);
        send(16'h0002);
        check("flushq_pre_valid", {31'd0, out_valid}, 32'd1);
        flush    = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0005;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        have_a   = 1'b0;
        check("flushq_valid", {31'd0, out_valid}, 32'd0);
        check("flushq_in_ready", {31'd0, in_ready}, 32'd1);
        send(16'h0009);
        send(16'h0003);
        drain();

        // Asynchronous reset mid-cycle
        out_ready = 1'b0;
        send(16'h0004);
        send(16'h0005);
        send(16'h0006);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        have_a    = 1'b0;
        exp_drops = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'h0009);
        send(16'h0003);
        check("arst_pair", out_data, 32'h0009_0003);
        drain();

        // Zero operands: dropped with the filter, forwarded without it
        send(16'h0000);
        send(16'h0005);
        send(16'h000C);
        send(16'h0008);
        drain();
`ifdef GCD_ZERO_FILTER_EN
        check("zero_drop_cnt", {24'd0, drop_cnt}, 32'(exp_drops));

        // Saturation of the drop counter
        for (int i = 0; i < 300; i++) begin
            send(16'h0000);
            send(16'h0000);
        end
        tick();
        check("sat_drop_cnt", {24'd0, drop_cnt}, 32'(exp_drops));
        check("sat_out_valid", {31'd0, out_valid}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
